// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the shared ALU; owns HI/LO.
// Optional MTHI/MTLO write port enabled by defining MDU_HILO_WR_EN.
//
// state | meaning
// IDLE  | waiting for start; HI/LO hold last result (or MTHI/MTLO writes)
// PREP  | take operand magnitudes, detect divide-by-zero, seed HI/LO
// MUL   | one shift-add iteration per cycle through the ALU
// DIV   | one restoring shift-subtract iteration per cycle through the ALU
// FIX   | apply result signs for signed ops
// FIN   | signal completion, return to IDLE
module mdu_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
`ifdef MDU_HILO_WR_EN
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
`endif
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_DIV, S_FIX, S_FIN} state_t;

  state_t      state_q;
  logic [31:0] hi_q, lo_q, rs_q, rt_q, opnd_q;
  logic [1:0]  op_q;
  logic        sign_q_q, sign_r_q;
  logic        busy_q, done_q, dbz_q;
  logic [4:0]  cnt_q;

  logic [31:0] abs_rs_d, abs_rt_d, div_a_d;
  logic        mul_carry_d, div_ge_d;

  assign abs_rs_d    = (op_q[0] && rs_q[31]) ? -rs_q : rs_q;
  assign abs_rt_d    = (op_q[0] && rt_q[31]) ? -rt_q : rt_q;
  assign div_a_d     = {hi_q[30:0], lo_q[31]};
  assign mul_carry_d = (alu_out < hi_q);
  // hi[31] set means the 33-bit partial remainder already exceeds any divisor
  assign div_ge_d    = hi_q[31] | (div_a_d >= opnd_q);

  always_comb begin
    alu_req = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 3'b010;
    if (state_q == S_MUL) begin
      alu_req = 1'b1;
      alu_a   = hi_q;
      alu_b   = opnd_q;
    end else if (state_q == S_DIV) begin
      alu_req = 1'b1;
      alu_a   = div_a_d;
      alu_b   = opnd_q;
      alu_op  = 3'b110;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_PREP;
            busy_q   <= 1'b1;
            dbz_q    <= 1'b0;
            rs_q     <= rs;
            rt_q     <= rt;
            op_q     <= op;
            sign_q_q <= op[0] & (rs[31] ^ rt[31]);
            sign_r_q <= op[0] & rs[31];
          end
`ifdef MDU_HILO_WR_EN
          else begin
            if (hilo_we[1]) hi_q <= hilo_wdata;
            if (hilo_we[0]) lo_q <= hilo_wdata;
          end
`endif
        end
        S_PREP: begin
          if (op_q[1] && (rt_q == '0)) begin
            hi_q    <= rs_q;
            lo_q    <= 32'hFFFF_FFFF;
            dbz_q   <= 1'b1;
            state_q <= S_FIN;
          end else begin
            hi_q  <= '0;
            cnt_q <= 5'(ITER - 1);
            if (op_q[1]) begin
              lo_q    <= abs_rs_d;
              opnd_q  <= abs_rt_d;
              state_q <= S_DIV;
            end else begin
              lo_q    <= abs_rt_d;
              opnd_q  <= abs_rs_d;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (lo_q[0]) {hi_q, lo_q} <= {mul_carry_d, alu_out, lo_q[31:1]};
          else         {hi_q, lo_q} <= {1'b0, hi_q, lo_q[31:1]};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_DIV: begin
          if (div_ge_d) begin
            hi_q <= alu_out;
            lo_q <= {lo_q[30:0], 1'b1};
          end else begin
            hi_q <= div_a_d;
            lo_q <= {lo_q[30:0], 1'b0};
          end
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          if (op_q == 2'b01 && sign_q_q) {hi_q, lo_q} <= -{hi_q, lo_q};
          if (op_q == 2'b11) begin
            if (sign_q_q) lo_q <= -lo_q;
            if (sign_r_q) hi_q <= -hi_q;
          end
          state_q <= S_FIN;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed bench for mdu_seq with an arithmetic reference model and a per-cycle compare.
// Exercises the MTHI/MTLO port when MDU_HILO_WR_EN is defined.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, div_by_zero, alu_req;
  logic [31:0] hi, lo, alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
`ifdef MDU_HILO_WR_EN
  logic [1:0]  hilo_we;
  logic [31:0] hilo_wdata;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_seq #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
`ifdef MDU_HILO_WR_EN
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
`endif
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  // Shared ALU stand-in: add for 010, subtract for 110
  assign alu_out = (alu_op == 3'b110) ? alu_a - alu_b : alu_a + alu_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] absv(input logic [1:0] o, input logic [31:0] x);
    return (o[0] && x[31]) ? -x : x;
  endfunction

  function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l,
                               output bit z, output int lat);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    lat = 35;
    p = '0;
    q = 0;
    r = 0;
    case (o)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: if (b != 0) p = {32'(a % b), 32'(a / b)};
      default: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
    endcase
    if (o[1] && b == 0) begin
      z = 1'b1;
      lat = 2;
      p = {a, 32'hFFFF_FFFF};
    end
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Reference model: age = edges since the accepted start, -1 when idle
  int          age = -1;
  int          cur_lat = 35;
  logic [1:0]  cur_op = '0;
  logic [31:0] cur_b = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_dbz = 1'b0, p_dbz = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      age = -1; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    end else if (age < 0) begin
      if (start) begin
        calc(op, rs, rt, p_hi, p_lo, p_dbz, cur_lat);
        cur_op = op;
        cur_b  = op[1] ? absv(op, rt) : absv(op, rs);
        age    = 0;
        m_dbz  = 1'b0;
      end
`ifdef MDU_HILO_WR_EN
      else begin
        if (hilo_we[1]) m_hi = hilo_wdata;
        if (hilo_we[0]) m_lo = hilo_wdata;
      end
`endif
    end else begin
      age++;
      if (age == cur_lat) begin
        age = -1; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
      end
    end
  end

  always @(negedge clk) begin
    bit req_e;
    if (chk_en) begin
      req_e = (age >= 1) && (age <= 32) && (cur_lat == 35);
      check("busy", 64'(busy), 64'(age >= 0));
      check("done", 64'(done), 64'(m_done));
      check("alu_req", 64'(alu_req), 64'(req_e));
      if (req_e) begin
        check("alu_op", 64'(alu_op), cur_op[1] ? 64'd6 : 64'd2);
        check("alu_b", 64'(alu_b), 64'(cur_b));
      end else begin
        check("alu_op_idle", 64'(alu_op), 64'd2);
        check("alu_a_idle", 64'(alu_a), 64'd0);
        check("alu_b_idle", 64'(alu_b), 64'd0);
      end
      if (age < 0) begin
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      end
    end
  end

  // Launch an op, optionally re-pulse start on edges p1..p3 (counted from the accept edge)
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit ez,
                        input int elat, input int p1, input int p2, input int p3);
    int n, reqs;
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    reqs = 0;
    while (n < 80) begin
      @(posedge clk);
      n++;
      #1;
      if (alu_req) reqs++;
      if (done) break;
      if (n == p1 - 1 || n == p2 - 1 || n == p3 - 1) begin
        start = 1'b1; rs = 32'hDEAD_0000; op = 2'b10;
      end else begin
        start = 1'b0; rs = a; op = o;
      end
    end
    start = 1'b0;
    if (n >= 80) check("done_timeout", 64'(n), 64'(elat));
    else begin
      check("latency", 64'(n), 64'(elat));
      check("alu_req_cycles", 64'(reqs), (elat == 35) ? 64'd32 : 64'd0);
      check("hi_lit", 64'(hi), 64'(eh));
      check("lo_lit", 64'(lo), 64'(el));
      check("dbz_lit", 64'(div_by_zero), 64'(ez));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0;
`ifdef MDU_HILO_WR_EN
    hilo_we = '0; hilo_wdata = '0;
`endif
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 0, 0, 0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 35, 0, 0, 0);
    run_op(2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 35, 0, 0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 0, 0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 0, 0, 0);
    run_op(2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 2,  0, 0, 0);
    run_op(2'b00, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 35, 0, 0, 0);
    // start pulses during the op and in the FIN cycle must be ignored
    run_op(2'b00, 32'd1000,      32'd1000,      32'd0,         32'd1000000,   1'b0, 35, 5, 20, 35);
    repeat (3) @(posedge clk);
    #1;
    check("no_restart_after_fin", 64'(busy), 64'd0);

    // abort mid-iteration
    @(negedge clk);
    op = 2'b00; rs = 32'd5; rt = 32'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 35, 0, 0, 0);

`ifdef MDU_HILO_WR_EN
    @(negedge clk);
    hilo_we = 2'b10; hilo_wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hilo_we = 2'b00;
    check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthi_lo", 64'(lo), 64'd12);
    // write held across start and the whole op is dropped
    hilo_we = 2'b11; hilo_wdata = 32'h1111_1111;
    run_op(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 35, 0, 0, 0);
    hilo_we = 2'b00;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
